conv_mac_stream: RTL and testbench

Streaming, parametrised successor to the single-window convolution MAC in the YOLO datapath. It accepts one FILTER_SIZE×FILTER_SIZE pixel window and its matching weight window per handshake beat, then multiplies them element-wise in signed arithmetic. The products pass through a registered adder tree, and the window sums are accumulated over NUM_CH input channels. One output-pixel value is emitted per NUM_CH accepted beats, with valid/ready backpressure, between the window generator and the output feature-map writer.

---
 rtl/conv_mac_stream.sv | 110 +++++++++++
 tb/tb_conv_mac_stream.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_stream.sv
// Streaming convolution MAC: element-wise signed window products, registered adder tree, per-pixel channel accumulation.
// Optional build macro CONV_MAC_RELU_EN clamps negative results to zero on output.
module conv_mac_stream #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int FILTER_SIZE   = 3,
    parameter int NUM_CH        = 4,
    parameter int ACC_WIDTH     = 32
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [FILTER_SIZE*FILTER_SIZE*IP_DATA_WIDTH-1:0] in_pix,
    input  logic [FILTER_SIZE*FILTER_SIZE*IP_DATA_WIDTH-1:0] in_wgt,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [ACC_WIDTH-1:0]                             out_data,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   ch_cnt
);

    localparam int K2 = FILTER_SIZE * FILTER_SIZE;
    localparam int PW = 2 * IP_DATA_WIDTH;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

    logic                        stall;
    logic                        accept;
    logic                        vld_p1, first_p1, last_p1;
    logic signed [PW-1:0]        prod_p1 [K2];
    logic                        vld_p2, first_p2, last_p2;
    logic signed [ACC_WIDTH-1:0] sum_p2;
    logic signed [ACC_WIDTH-1:0] sum_c;
    logic signed [ACC_WIDTH-1:0] acc_p3;
    logic signed [ACC_WIDTH-1:0] acc_next;

    function automatic logic signed [PW-1:0] mul_elem(input logic signed [IP_DATA_WIDTH-1:0] a,
                                                      input logic signed [IP_DATA_WIDTH-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic signed [PW-1:0] p);
        return {{(ACC_WIDTH - PW){p[PW-1]}}, p};
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] out_clamp(input logic signed [ACC_WIDTH-1:0] v);
`ifdef CONV_MAC_RELU_EN
        return v[ACC_WIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // A pending, unaccepted result freezes every stage at once.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum_c = '0;
        for (int e = 0; e < K2; e++) begin
            sum_c = sum_c + sext_prod(prod_p1[e]);
        end
    end

    assign acc_next = first_p2 ? sum_p2 : acc_p3 + sum_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            ch_cnt    <= '0;
            acc_p3    <= '0;
            out_data  <= '0;
        end else if (!stall) begin
            // stage 1: tag the beat by channel position
            vld_p1 <= accept;
            if (accept) begin
                first_p1 <= (ch_cnt == '0);
                last_p1  <= (ch_cnt == LAST_CH);
                ch_cnt   <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + CW'(1);
            end
            // stage 2: window sum
            vld_p2   <= vld_p1;
            first_p2 <= first_p1;
            last_p2  <= last_p1;
            // stage 3: accumulate and publish on the last channel
            if (vld_p2) begin
                acc_p3 <= acc_next;
            end
            out_valid <= vld_p2 && last_p2;
            if (vld_p2 && last_p2) begin
                out_data <= out_clamp(acc_next);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int e = 0; e < K2; e++) begin
                prod_p1[e] <= mul_elem(in_pix[e*IP_DATA_WIDTH +: IP_DATA_WIDTH],
                                       in_wgt[e*IP_DATA_WIDTH +: IP_DATA_WIDTH]);
            end
        end
        if (!stall && vld_p1) begin
            sum_p2 <= sum_c;
        end
    end

endmodule

// File: tb/tb_conv_mac_stream.sv
// Directed bench for conv_mac_stream: a NUM_CH=4 instance and a NUM_CH=1 instance.
module tb_conv_mac_stream;

    logic clk;
    logic rst;

    logic               in_valid0, in_ready0, out_valid0, out_ready0;
    logic [71:0]        in_pix0, in_wgt0;
    logic signed [31:0] out_data0;
    logic [1:0]         ch_cnt0;

    logic               in_valid1, in_ready1, out_valid1, out_ready1;
    logic [71:0]        in_pix1, in_wgt1;
    logic signed [31:0] out_data1;
    logic [0:0]         ch_cnt1;

    int checks = 0;
    int failures = 0;

    conv_mac_stream #(.IP_DATA_WIDTH(8), .FILTER_SIZE(3), .NUM_CH(4), .ACC_WIDTH(32)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_pix(in_pix0), .in_wgt(in_wgt0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_data(out_data0), .ch_cnt(ch_cnt0)
    );

    conv_mac_stream #(.IP_DATA_WIDTH(8), .FILTER_SIZE(3), .NUM_CH(1), .ACC_WIDTH(32)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_pix(in_pix1), .in_wgt(in_wgt1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_data(out_data1), .ch_cnt(ch_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] fill(input logic [7:0] v);
        logic [71:0] w;
        for (int e = 0; e < 9; e++) w[e*8 +: 8] = v;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_pixel(input string tag, input logic [7:0] pv, input logic [7:0] wv,
                             input longint exp);
        in_pix0   = fill(pv);
        in_wgt0   = fill(wv);
        in_valid0 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check({tag, "_ch_cnt"}, longint'(ch_cnt0), longint'(c));
            check({tag, "_in_ready"}, longint'(in_ready0), 1);
            step();
        end
        in_valid0 = 1'b0;
        check({tag, "_valid_n"}, longint'(out_valid0), 0);
        step();
        check({tag, "_valid_n1"}, longint'(out_valid0), 0);
        step();
        check({tag, "_valid_n2"}, longint'(out_valid0), 1);
        check({tag, "_data"}, longint'(out_data0), exp);
        check({tag, "_ch_wrap"}, longint'(ch_cnt0), 0);
        step();
        check({tag, "_valid_clr"}, longint'(out_valid0), 0);
    endtask

    initial begin
        int b;
        int stall_left;
        int stalled;
        int nres;
        bit seen;
        bit acc_ok;
        logic signed [31:0] res [4];
        longint neg_exp;

        rst = 1'b1;
        in_valid0 = 1'b0; in_pix0 = '0; in_wgt0 = '0; out_ready0 = 1'b1;
        in_valid1 = 1'b0; in_pix1 = '0; in_wgt1 = '0; out_ready1 = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", longint'(in_ready0), 1);
        check("rst_out_valid", longint'(out_valid0), 0);
        check("rst_out_data", longint'(out_data0), 0);
        check("rst_ch_cnt", longint'(ch_cnt0), 0);

        run_pixel("ones_twos", 8'sd1, 8'sd2, 72);
`ifdef CONV_MAC_RELU_EN
        neg_exp = 0;
`else
        neg_exp = -108;
`endif
        run_pixel("neg", -8'sd1, 8'sd3, neg_exp);
        run_pixel("min_min", 8'h80, 8'h80, 589824);

        // 8 continuous beats with a 5-cycle downstream stall on the first result
        b = 0; stall_left = 0; stalled = 0; nres = 0; seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (out_valid0 && !seen) begin
                seen = 1'b1;
                stall_left = 5;
            end
            out_ready0 = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                check("stall_in_ready", longint'(in_ready0), 0);
                stall_left--;
                stalled++;
            end
            if (out_valid0 && out_ready0) begin
                if (nres < 4) res[nres] = out_data0;
                nres++;
            end
            if (b < 8) begin
                check("stream_ch_cnt", longint'(ch_cnt0), longint'(b % 4));
                in_pix0   = fill(8'(b % 4 + 1));
                in_wgt0   = fill(8'd1);
                in_valid0 = 1'b1;
            end else begin
                in_valid0 = 1'b0;
            end
            acc_ok = in_valid0 && in_ready0;
            step();
            if (acc_ok) b++;
        end
        out_ready0 = 1'b1;
        in_valid0  = 1'b0;
        check("stream_beats", longint'(b), 8);
        check("stream_stall_cycles", longint'(stalled), 5);
        check("stream_nres", longint'(nres), 2);
        if (nres >= 1) check("stream_res0", longint'(res[0]), 90);
        if (nres >= 2) check("stream_res1", longint'(res[1]), 90);

        // reset mid-pixel; rst held alongside a valid beat
        in_pix0 = fill(8'd1);
        in_wgt0 = fill(8'd1);
        in_valid0 = 1'b1;
        step();
        step();
        check("mid_ch_cnt", longint'(ch_cnt0), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid0 = 1'b0;
        check("mid_rst_ch_cnt", longint'(ch_cnt0), 0);
        check("mid_rst_out_valid", longint'(out_valid0), 0);
        check("mid_rst_out_data", longint'(out_data0), 0);
        run_pixel("after_rst", 8'd1, 8'd1, 36);

        // NUM_CH=1 with a bubble every other cycle
        for (int t = 0; t < 13; t++) begin
            if (t >= 3 && ((t - 3) % 2) == 0 && (t - 3) < 10) begin
                check("ch1_valid", longint'(out_valid1), 1);
                check("ch1_data", longint'(out_data1), longint'(18 * ((t - 3) / 2 + 1)));
            end else begin
                check("ch1_bubble", longint'(out_valid1), 0);
            end
            check("ch1_ch_cnt", longint'(ch_cnt1), 0);
            if ((t % 2) == 0 && t < 10) begin
                in_pix1   = fill(8'(t / 2 + 1));
                in_wgt1   = fill(8'd2);
                in_valid1 = 1'b1;
            end else begin
                in_valid1 = 1'b0;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
